// File: rtl/ser_pkg.sv
// ser_pkg: definitions shared by the serializer aggregate, the field-header
// logic and the byte writer. It holds the chunk and lane limits, the writer
// FSM encoding, and helpers that size a DRAM store.
package ser_pkg;
  localparam int SER_MAX_CHUNK = 10;  // varint worst case, in bytes
  localparam int SER_LANES     = 8;   // DRAM byte lanes per store
  localparam int SER_HDR_MAX   = 5;   // longest encoded field header

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RUN   = 3'd1,
    STORE = 3'd2,
    FLUSH = 3'd3,
    DONE  = 3'd4
  } ser_wr_state_t;

  // Number of lanes the next store uses: a full store, or the remainder.
  function automatic logic [3:0] ser_lane_count(input logic [7:0] fill);
    if (fill >= 8'(SER_LANES)) begin
      ser_lane_count = 4'(SER_LANES);
    end else begin
      ser_lane_count = fill[3:0];
    end
  endfunction

  // Low-lane enable mask, (1 << cnt) - 1, built without a variable shift.
  function automatic logic [SER_LANES-1:0] ser_lane_mask(input logic [3:0] cnt);
    logic [SER_LANES-1:0] m;
    m = '0;
    for (int k = 0; k < SER_LANES; k++) begin
      if (4'(k) < cnt) begin
        m[k] = 1'b1;
      end else begin
        m[k] = 1'b0;
      end
    end
    return m;
  endfunction
endpackage

// File: rtl/ser_wbuf_merge.sv
// ser_wbuf_merge: combinational update of the packing buffer. This is the
// only block that shifts or appends buffer bytes.
//   wbuf, fill   current buffer contents and the number of valid bytes
//   in_data      chunk bytes, byte 0 first
//   in_len       bytes to append (0 when nothing is accepted)
//   drain8       a store retires this cycle, so the low 8 bytes leave
//   next_buf     buffer after the drain and then the append
//   next_fill    valid bytes after the drain and then the append
module ser_wbuf_merge
  import ser_pkg::*;
#(
  parameter int BUF_BYTES  = 16,
  parameter int MAX_CHUNK  = SER_MAX_CHUNK,
  parameter int LANES      = SER_LANES,
  localparam int FW        = $clog2(BUF_BYTES + 1),
  localparam int IW        = $clog2(MAX_CHUNK)
) (
  input  logic [BUF_BYTES-1:0][7:0] wbuf,
  input  logic [FW-1:0]             fill,
  input  logic [MAX_CHUNK-1:0][7:0] in_data,
  input  logic [3:0]                in_len,
  input  logic                      drain8,
  output logic [BUF_BYTES-1:0][7:0] next_buf,
  output logic [FW-1:0]             next_fill
);
  logic [BUF_BYTES-1:0][7:0] shifted_s;
  logic [FW-1:0]             base_s;

  // Drain first, then append the chunk at the post-drain fill level.
  always_comb begin
    if (drain8) begin
      shifted_s = wbuf >> (8 * LANES);
      // A partial (final) store empties the buffer completely.
      if (fill >= FW'(LANES)) begin
        base_s = fill - FW'(LANES);
      end else begin
        base_s = '0;
      end
    end else begin
      shifted_s = wbuf;
      base_s    = fill;
    end
    next_buf = shifted_s;
    for (int j = 0; j < BUF_BYTES; j++) begin
      if ((FW'(j) >= base_s) && ((FW'(j) - base_s) < FW'(in_len))) begin
        next_buf[j] = in_data[IW'(FW'(j) - base_s)];
      end else begin
        next_buf[j] = shifted_s[j];
      end
    end
    next_fill = base_s + FW'(in_len);
  end
endmodule

// File: rtl/ser_byte_writer.sv
// ser_byte_writer: packs variable-length byte chunks into a small buffer and
// drains it to DRAM in stores of up to 8 consecutive byte lanes. The result is
// the contiguous wire image starting at base_addr.
//   clk, reset        clock and synchronous active-high reset
//   start, base_addr  begin a new image at base_addr (accepted only in IDLE)
//   in_valid/in_data/in_len/in_ready   chunk handshake
//   flush, done       drain everything that is buffered; done pulses at the end
//   err               sticky flag for an over-long chunk
//   bytes_written     bytes committed to DRAM since start
//   dram_*            per-lane store port; the store completes when every
//                     enabled lane is acked in the same cycle
module ser_byte_writer
  import ser_pkg::*;
#(
  parameter int BUF_BYTES = 16,
  parameter int MAX_CHUNK = SER_MAX_CHUNK,
  parameter int LANES     = SER_LANES,
  localparam int FW       = $clog2(BUF_BYTES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [63:0]                base_addr,
  input  logic                       in_valid,
  input  logic [MAX_CHUNK-1:0][7:0]  in_data,
  input  logic [3:0]                 in_len,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       done,
  output logic                       err,
  output logic [63:0]                bytes_written,
  output logic [LANES-1:0]           dram_en,
  output logic                       dram_rdwr,
  output logic [LANES-1:0][63:0]     dram_addr,
  output logic [LANES-1:0][7:0]      dram_data_out,
  input  logic [LANES-1:0]           dram_valid
);
  ser_wr_state_t             state_r, state_n;
  logic [BUF_BYTES-1:0][7:0] wbuf_r, wbuf_n, merge_buf_s;
  logic [FW-1:0]             fill_r, fill_n, merge_fill_s;
  logic [63:0]               wr_ptr_r, wr_ptr_n, bw_n;
  logic [3:0]                store_cnt_r, store_cnt_n, issue_cnt_s;
  logic                      flush_pend_r, flush_pend_n;
  logic                      err_n, done_n, in_ready_n, rdwr_n;
  logic [LANES-1:0]          en_n;
  logic [LANES-1:0][63:0]    addr_n;
  logic [LANES-1:0][7:0]     data_n;
  logic                      issue_s, clr_buf_s;
  logic                      accept_s, bad_len_s, complete_s, drain_s;
  logic [3:0]                app_len_s;

  assign accept_s   = in_valid && in_ready && ((state_r == RUN) || (state_r == STORE));
  assign bad_len_s  = accept_s && (in_len > 4'(MAX_CHUNK));
  assign app_len_s  = (accept_s && !bad_len_s) ? in_len : 4'd0;
  assign complete_s = (dram_en != '0) && ((dram_valid & dram_en) == dram_en);
  assign drain_s    = complete_s && ((state_r == STORE) || (state_r == FLUSH));

  ser_wbuf_merge #(
    .BUF_BYTES (BUF_BYTES),
    .MAX_CHUNK (MAX_CHUNK),
    .LANES     (LANES)
  ) u_merge (
    .wbuf      (wbuf_r),
    .fill      (fill_r),
    .in_data   (in_data),
    .in_len    (app_len_s),
    .drain8    (drain_s),
    .next_buf  (merge_buf_s),
    .next_fill (merge_fill_s)
  );

  // Next-state and next-output logic for the writer FSM.
  always_comb begin
    state_n      = state_r;
    wr_ptr_n     = wr_ptr_r;
    bw_n         = bytes_written;
    err_n        = err | bad_len_s;
    flush_pend_n = flush_pend_r;
    store_cnt_n  = store_cnt_r;
    clr_buf_s    = 1'b0;
    issue_s      = 1'b0;
    issue_cnt_s  = 4'd0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_n      = RUN;
          wr_ptr_n     = base_addr;
          bw_n         = 64'd0;
          err_n        = 1'b0;
          flush_pend_n = 1'b0;
          clr_buf_s    = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        if (fill_r >= FW'(LANES)) begin
          issue_s      = 1'b1;
          issue_cnt_s  = 4'(LANES);
          state_n      = STORE;
          flush_pend_n = flush_pend_r | flush;
        end else if (flush || flush_pend_r) begin
          state_n      = FLUSH;
          flush_pend_n = 1'b0;
        end else begin
          state_n = RUN;
        end
      end
      STORE: begin
        // A flush seen mid-store waits until the store retires.
        flush_pend_n = flush_pend_r | flush;
        if (complete_s) begin
          state_n = RUN;
        end else begin
          state_n = STORE;
        end
      end
      FLUSH: begin
        if (dram_en != '0) begin
          if (complete_s) begin
            // Nothing is appended during FLUSH, so fill <= 8 means the buffer is now empty.
            if (fill_r <= FW'(LANES)) begin
              state_n = DONE;
            end else begin
              state_n = FLUSH;
            end
          end else begin
            state_n = FLUSH;
          end
        end else if (fill_r == '0) begin
          state_n = DONE;
        end else begin
          issue_s     = 1'b1;
          issue_cnt_s = ser_lane_count(8'(fill_r));
          state_n     = FLUSH;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    if (drain_s) begin
      wr_ptr_n = wr_ptr_r + 64'(store_cnt_r);
      bw_n     = bytes_written + 64'(store_cnt_r);
    end else begin
      wr_ptr_n = wr_ptr_n;
      bw_n     = bw_n;
    end

    en_n   = dram_en;
    addr_n = dram_addr;
    data_n = dram_data_out;
    if (issue_s) begin
      store_cnt_n = issue_cnt_s;
      en_n        = ser_lane_mask(issue_cnt_s);
      for (int k = 0; k < LANES; k++) begin
        if (4'(k) < issue_cnt_s) begin
          addr_n[k] = wr_ptr_r + 64'(k);
          data_n[k] = wbuf_r[k];
        end else begin
          addr_n[k] = 64'd0;
          data_n[k] = 8'h00;
        end
      end
    end else if (drain_s) begin
      en_n   = '0;
      addr_n = '0;
      data_n = '0;
    end else begin
      store_cnt_n = store_cnt_r;
    end

    if (clr_buf_s) begin
      wbuf_n = '0;
      fill_n = '0;
    end else begin
      wbuf_n = merge_buf_s;
      fill_n = merge_fill_s;
    end

    rdwr_n     = (en_n != '0);
    done_n     = (state_n == DONE);
    // Register the room check so in_ready reflects the fill level of the cycle it is seen in.
    in_ready_n = ((state_n == RUN) || (state_n == STORE)) &&
                 ((int'(fill_n) + MAX_CHUNK) <= BUF_BYTES);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      wbuf_r        <= '0;
      fill_r        <= '0;
      wr_ptr_r      <= 64'd0;
      store_cnt_r   <= 4'd0;
      flush_pend_r  <= 1'b0;
      in_ready      <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      bytes_written <= 64'd0;
      dram_en       <= '0;
      dram_rdwr     <= 1'b0;
      dram_addr     <= '0;
      dram_data_out <= '0;
    end else begin
      state_r       <= state_n;
      wbuf_r        <= wbuf_n;
      fill_r        <= fill_n;
      wr_ptr_r      <= wr_ptr_n;
      store_cnt_r   <= store_cnt_n;
      flush_pend_r  <= flush_pend_n;
      in_ready      <= in_ready_n;
      done          <= done_n;
      err           <= err_n;
      bytes_written <= bw_n;
      dram_en       <= en_n;
      dram_rdwr     <= rdwr_n;
      dram_addr     <= addr_n;
      dram_data_out <= data_n;
    end
  end
endmodule

// File: tb/tb_ser_byte_writer.sv
// Testbench for ser_byte_writer: a cycle-by-cycle vector table for the basic
// pack/store/flush flow, plus hand-written sequences for stalls, partial
// acks, bad lengths, address wrap and reset during a store.
module tb_ser_byte_writer;
  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [63:0]      base_addr;
  logic             in_valid;
  logic [9:0][7:0]  in_data;
  logic [3:0]       in_len;
  logic             in_ready;
  logic             flush;
  logic             done;
  logic             err;
  logic [63:0]      bytes_written;
  logic [7:0]       dram_en;
  logic             dram_rdwr;
  logic [7:0][63:0] dram_addr;
  logic [7:0][7:0]  dram_data_out;
  logic [7:0]       dram_valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ser_byte_writer dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .base_addr     (base_addr),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_len        (in_len),
    .in_ready      (in_ready),
    .flush         (flush),
    .done          (done),
    .err           (err),
    .bytes_written (bytes_written),
    .dram_en       (dram_en),
    .dram_rdwr     (dram_rdwr),
    .dram_addr     (dram_addr),
    .dram_data_out (dram_data_out),
    .dram_valid    (dram_valid)
  );

  typedef struct {
    logic        start;
    logic [63:0] base;
    logic        valid;
    logic [3:0]  len;
    logic [79:0] data;
    logic        flush;
    logic [7:0]  dv;
    logic        exp_ready;
    logic [7:0]  exp_en;
    logic [63:0] exp_addr0;
    logic [63:0] exp_data;
    logic        exp_done;
    logic [63:0] exp_bw;
  } vec_t;

  vec_t vecs [0:22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    start    = 1'b0;
    in_valid = 1'b0;
    in_len   = 4'd0;
    in_data  = '0;
    flush    = 1'b0;
  endtask

  task automatic chunk(input logic [3:0] len, input logic [79:0] data);
    in_valid = 1'b1;
    in_len   = len;
    in_data  = data;
  endtask

  initial begin
    logic [63:0] wrap_addr [0:7];
    wrap_addr = '{64'hFFFF_FFFF_FFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFD,
                  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0, 64'h1, 64'h2, 64'h3};

    // Test 1: base 0x1000, chunks of 5 and 5, flush while the first store is pending.
    vecs[0]  = '{1'b1, 64'h1000, 1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    vecs[1]  = '{1'b0, 64'h0,    1'b1, 4'd5, 80'h1514131211,  1'b0, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    vecs[2]  = '{1'b0, 64'h0,    1'b1, 4'd5, 80'h1A19181716,  1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    vecs[3]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b1, 8'hFF, 1'b0, 8'hFF, 64'h1000, 64'h1817161514131211,    1'b0, 64'd0};
    vecs[4]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd8};
    vecs[5]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd8};
    vecs[6]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h03, 64'h1008, 64'h1A19,                1'b0, 64'd8};
    vecs[7]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b1, 64'd10};
    vecs[8]  = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd10};
    // Test 2: bytes 01..0A at base 0x2000; single bytes until fill 6, then the rest
    // in one chunk (at fill 7 in_ready would stay low with no store to free room).
    vecs[9]  = '{1'b1, 64'h2000, 1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    for (int i = 0; i < 6; i++) begin
      vecs[10 + i] = '{1'b0, 64'h0, 1'b1, 4'd1, 80'(i + 1),   1'b0, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    end
    vecs[16] = '{1'b0, 64'h0,    1'b1, 4'd4, 80'h0A090807,    1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd0};
    vecs[17] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'hFF, 64'h2000, 64'h0807060504030201,    1'b0, 64'd0};
    vecs[18] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b1, 8'hFF, 1'b1, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd8};
    vecs[19] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd8};
    vecs[20] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h03, 64'h2008, 64'h0A09,                1'b0, 64'd8};
    vecs[21] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b1, 64'd10};
    vecs[22] = '{1'b0, 64'h0,    1'b0, 4'd0, 80'h0,           1'b0, 8'hFF, 1'b0, 8'h00, 64'h0,    64'h0,                   1'b0, 64'd10};

    // Reset state
    quiet();
    base_addr  = 64'h0;
    dram_valid = 8'h00;
    reset      = 1'b1;
    step();
    step();
    chk("rst.in_ready", 64'(in_ready), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.err", 64'(err), 64'd0);
    chk("rst.bw", bytes_written, 64'd0);
    chk("rst.en", 64'(dram_en), 64'd0);
    chk("rst.rdwr", 64'(dram_rdwr), 64'd0);
    chk("rst.addr0", dram_addr[0], 64'd0);
    chk("rst.data", dram_data_out, 64'd0);
    reset = 1'b0;
    step();

    // Tests 1 and 2 from the vector table
    for (int i = 0; i < 23; i++) begin
      start      = vecs[i].start;
      base_addr  = vecs[i].base;
      in_valid   = vecs[i].valid;
      in_len     = vecs[i].len;
      in_data    = vecs[i].data;
      flush      = vecs[i].flush;
      dram_valid = vecs[i].dv;
      step();
      chk($sformatf("v%0d.ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
      chk($sformatf("v%0d.en", i), 64'(dram_en), 64'(vecs[i].exp_en));
      chk($sformatf("v%0d.rdwr", i), 64'(dram_rdwr), 64'(vecs[i].exp_en != 8'h00));
      chk($sformatf("v%0d.addr0", i), dram_addr[0], vecs[i].exp_addr0);
      chk($sformatf("v%0d.data", i), dram_data_out, vecs[i].exp_data);
      chk($sformatf("v%0d.done", i), 64'(done), 64'(vecs[i].exp_done));
      chk($sformatf("v%0d.bw", i), bytes_written, vecs[i].exp_bw);
      chk($sformatf("v%0d.err", i), 64'(err), 64'd0);
    end

    // Test 3: DRAM stall holds the store stable; in_ready low above fill 6
    quiet();
    dram_valid = 8'h00;
    start = 1'b1; base_addr = 64'h3000;
    step();
    quiet();
    chunk(4'd5, 80'h3534333231);
    step();
    chk("t3.ready_fill5", 64'(in_ready), 64'd1);
    chunk(4'd5, 80'h3A39383736);
    step();
    chk("t3.ready_fill10", 64'(in_ready), 64'd0);
    quiet();
    step();
    chk("t3.en", 64'(dram_en), 64'hFF);
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("t3.stall%0d.en", c), 64'(dram_en), 64'hFF);
      chk($sformatf("t3.stall%0d.addr0", c), dram_addr[0], 64'h3000);
      chk($sformatf("t3.stall%0d.addr7", c), dram_addr[7], 64'h3007);
      chk($sformatf("t3.stall%0d.data", c), dram_data_out, 64'h3837363534333231);
      chk($sformatf("t3.stall%0d.ready", c), 64'(in_ready), 64'd0);
      chk($sformatf("t3.stall%0d.bw", c), bytes_written, 64'd0);
    end
    dram_valid = 8'hFF;
    step();
    chk("t3.resume.en", 64'(dram_en), 64'h00);
    chk("t3.resume.bw", bytes_written, 64'd8);
    chk("t3.resume.ready", 64'(in_ready), 64'd1);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t3.tail.en", 64'(dram_en), 64'h03);
    chk("t3.tail.addr0", dram_addr[0], 64'h3008);
    chk("t3.tail.data", dram_data_out, 64'h3A39);
    step();
    chk("t3.done", 64'(done), 64'd1);
    chk("t3.bw", bytes_written, 64'd10);
    step();

    // Test 4: partial acks do not complete a store; start while running is ignored
    dram_valid = 8'h00;
    start = 1'b1; base_addr = 64'h4000;
    step();
    start = 1'b1; base_addr = 64'h9990;
    chunk(4'd8, 80'hA7A6A5A4A3A2A1A0);
    step();
    quiet();
    chk("t4.ready", 64'(in_ready), 64'd0);
    step();
    chk("t4.issue.en", 64'(dram_en), 64'hFF);
    chk("t4.issue.addr0", dram_addr[0], 64'h4000);
    dram_valid = 8'h0F;
    step();
    chk("t4.ack0F.en", 64'(dram_en), 64'hFF);
    chk("t4.ack0F.bw", bytes_written, 64'd0);
    dram_valid = 8'hF0;
    step();
    chk("t4.ackF0.en", 64'(dram_en), 64'hFF);
    chk("t4.ackF0.addr0", dram_addr[0], 64'h4000);
    chk("t4.ackF0.bw", bytes_written, 64'd0);
    dram_valid = 8'hFF;
    step();
    chk("t4.ackFF.en", 64'(dram_en), 64'h00);
    chk("t4.ackFF.bw", bytes_written, 64'd8);
    chk("t4.ackFF.ready", 64'(in_ready), 64'd1);

    // Test 5: over-long chunk sets err and is dropped; zero-length is a no-op
    dram_valid = 8'h00;
    chunk(4'd12, 80'hEEEEEEEEEEEEEEEEEEEE);
    step();
    chk("t5.err", 64'(err), 64'd1);
    chk("t5.ready_after_bad", 64'(in_ready), 64'd1);
    chunk(4'd0, 80'hDDDDDDDDDDDDDDDDDDDD);
    step();
    chk("t5.err_sticky", 64'(err), 64'd1);
    chk("t5.ready_after_zero", 64'(in_ready), 64'd1);
    chunk(4'd8, 80'hB7B6B5B4B3B2B1B0);
    step();
    quiet();
    step();
    chk("t5.store.data", dram_data_out, 64'hB7B6B5B4B3B2B1B0);
    chk("t5.store.addr0", dram_addr[0], 64'h4008);
    dram_valid = 8'hFF;
    step();
    chk("t5.store.bw", bytes_written, 64'd16);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    chk("t5.empty_flush.done", 64'(done), 64'd1);
    chk("t5.empty_flush.en", 64'(dram_en), 64'h00);
    chk("t5.empty_flush.bw", bytes_written, 64'd16);
    step();
    chk("t5.done_one_cycle", 64'(done), 64'd0);
    chk("t5.err_held_idle", 64'(err), 64'd1);
    start = 1'b1; base_addr = 64'h5000;
    step();
    start = 1'b0;
    chk("t5.start.err", 64'(err), 64'd0);
    chk("t5.start.bw", bytes_written, 64'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    step();
    step();

    // Test 6: lane addresses wrap past 2^64-1; reset mid-store clears everything
    dram_valid = 8'h00;
    start = 1'b1; base_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    quiet();
    chunk(4'd8, 80'hC7C6C5C4C3C2C1C0);
    step();
    quiet();
    step();
    chk("t6.en", 64'(dram_en), 64'hFF);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6.addr%0d", k), dram_addr[k], wrap_addr[k]);
    end
    reset = 1'b1;
    dram_valid = 8'hFF;
    step();
    chk("t6.rst.en", 64'(dram_en), 64'h00);
    chk("t6.rst.rdwr", 64'(dram_rdwr), 64'd0);
    chk("t6.rst.data", dram_data_out, 64'd0);
    chk("t6.rst.ready", 64'(in_ready), 64'd0);
    chk("t6.rst.done", 64'(done), 64'd0);
    chk("t6.rst.err", 64'(err), 64'd0);
    chk("t6.rst.bw", bytes_written, 64'd0);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("t6.rst.addr%0d", k), dram_addr[k], 64'd0);
    end
    reset = 1'b0;
    step();
    step();
    chk("t6.idle.en", 64'(dram_en), 64'h00);
    chk("t6.idle.ready", 64'(in_ready), 64'd0);
    chk("t6.idle.bw", bytes_written, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
